// File: rtl/mcb_test_pkg.sv
// rtl/mcb_test_pkg.sv - shared encodings, pattern constants and LFSR step for the MCB test engines
package mcb_test_pkg;

  typedef enum logic [1:0] {
    MODE_AA55 = 2'd0,
    MODE_ADDR = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;
  localparam logic [1:0] ST_NEXT      = 2'd3;

  localparam logic [7:0] PAT_AA = 8'hAA;
  localparam logic [7:0] PAT_55 = 8'h55;

  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/mcb_pattern_gen.sv
// rtl/mcb_pattern_gen.sv - expected data word per beat; shared by the read checker and write generator
module mcb_pattern_gen
  import mcb_test_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 30,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  beat_i,
  input  logic              advance_i,
  input  logic              seed_i,
  output logic [DATA_W-1:0] exp_o
);

  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] addr_lane;

  assign addr_lane = 32'(addr_i) + 32'(beat_i);

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_i) begin
      lfsr_d = LFSR_SEED;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    exp_o = '0;
    case (mode_i)
      MODE_ADDR: exp_o = {(DATA_W/32){addr_lane}};
      MODE_LFSR: exp_o = {(DATA_W/32){lfsr_q}};
      default:   exp_o = beat_i[0] ? {(DATA_W/8){PAT_55}} : {(DATA_W/8){PAT_AA}};
    endcase
  end

endmodule

// File: rtl/mcb_read_checker.sv
// rtl/mcb_read_checker.sv - MCB read-path sweep checker; MCB_RD_ERR_CAPTURE_EN adds first-error capture ports
module mcb_read_checker
  import mcb_test_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                ADDR_W    = 30,
  parameter int                LEN_W     = 7,
  parameter int                BURST_LEN = 64,
  parameter logic [ADDR_W-1:0] ADDR_INC  = 'h400,
  parameter logic [ADDR_W-1:0] END_ADDR  = 'h0FFF_FC00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              err_clr,
  output logic              rd_cmd_en,
  input  logic              rd_cmd_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [31:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic              err_flag
`ifdef MCB_RD_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [LEN_W-1:0]  first_err_beat,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp
`endif
);

  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(BURST_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              data_done_q, data_done_d;
  logic [31:0]       pass_q, pass_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d;

  logic              accept, spurious, last_beat, mismatch, leave_idle;
  logic [DATA_W-1:0] exp_data;

  // Beats arriving before the command handshake completes still belong to this burst
  assign accept     = rd_valid && (state_q == ST_ISSUE || state_q == ST_WAIT_DATA);
  assign spurious   = rd_valid && (state_q == ST_IDLE || state_q == ST_NEXT);
  assign last_beat  = accept && (beat_q == LAST_BEAT);
  assign mismatch   = spurious || (accept && (rd_data != exp_data));
  assign leave_idle = (state_q == ST_IDLE) && start;

  mcb_pattern_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_pattern_gen (
    .clk       (clk),
    .rst       (rst),
    .mode_i    (mode_q),
    .addr_i    (addr_q),
    .beat_i    (beat_q),
    .advance_i (accept),
    .seed_i    (leave_idle),
    .exp_o     (exp_data)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    data_done_d = data_done_q;
    pass_d      = pass_q;
    if (accept) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode;
          data_done_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (last_beat) begin
          data_done_d = 1'b1;
        end
        if (rd_cmd_done) begin
          state_d = (data_done_q || last_beat) ? ST_NEXT : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (last_beat || data_done_q) begin
          state_d = ST_NEXT;
        end
      end
      default: begin
        data_done_d = 1'b0;
        beat_d      = '0;
        if (addr_q == END_ADDR) begin
          addr_d = '0;
          pass_d = pass_q + 32'd1;
        end else begin
          addr_d = addr_q + ADDR_INC;
        end
        state_d = start ? ST_ISSUE : ST_IDLE;
      end
    endcase
  end

  // A clear in the same cycle as a mismatch discards that mismatch
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (err_clr) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_AA55;
      addr_q      <= '0;
      beat_q      <= '0;
      data_done_q <= 1'b0;
      pass_q      <= '0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      data_done_q <= data_done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
    end
  end

`ifdef MCB_RD_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] cap_addr_q;
  logic [LEN_W-1:0]  cap_beat_q;
  logic [DATA_W-1:0] cap_data_q, cap_exp_q;

  // err_flag low means nothing has been captured since reset or the last clear
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      cap_addr_q <= '0;
      cap_beat_q <= '0;
      cap_data_q <= '0;
      cap_exp_q  <= '0;
    end else if (mismatch && !err_flag_q) begin
      cap_addr_q <= addr_q;
      cap_beat_q <= beat_q;
      cap_data_q <= rd_data;
      cap_exp_q  <= exp_data;
    end
  end

  assign first_err_addr = cap_addr_q;
  assign first_err_beat = cap_beat_q;
  assign first_err_data = cap_data_q;
  assign first_err_exp  = cap_exp_q;
`endif

  assign rd_cmd_en = (state_q == ST_ISSUE);
  assign rd_addr   = addr_q;
  assign rd_len    = LAST_BEAT;
  assign busy      = (state_q != ST_IDLE);
  assign pass_cnt  = pass_q;
  assign err_cnt   = err_cnt_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_mcb_read_checker.sv
// tb/tb_mcb_read_checker.sv - self-checking bench for mcb_read_checker
module tb_mcb_read_checker;

  localparam int DW = 128;
  localparam int AW = 30;
  localparam int LW = 7;
  localparam int BL = 4;
  localparam logic [AW-1:0] INC   = 30'h400;
  localparam logic [AW-1:0] END_A = 30'h800;

  logic          clk = 1'b0;
  logic          rst, start, err_clr, rd_cmd_done, rd_valid;
  logic [1:0]    mode;
  logic [DW-1:0] rd_data;
  logic          rd_cmd_en, busy, err_flag;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_len;
  logic [31:0]   pass_cnt;
  logic [15:0]   err_cnt;
`ifdef MCB_RD_ERR_CAPTURE_EN
  logic [AW-1:0] first_err_addr;
  logic [LW-1:0] first_err_beat;
  logic [DW-1:0] first_err_data, first_err_exp;
`endif

  always #5 clk = ~clk;

  mcb_read_checker #(
    .DATA_W (DW), .ADDR_W (AW), .LEN_W (LW), .BURST_LEN (BL),
    .ADDR_INC (INC), .END_ADDR (END_A)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .mode (mode), .err_clr (err_clr),
    .rd_cmd_en (rd_cmd_en), .rd_cmd_done (rd_cmd_done), .rd_addr (rd_addr),
    .rd_len (rd_len), .rd_valid (rd_valid), .rd_data (rd_data), .busy (busy),
    .pass_cnt (pass_cnt), .err_cnt (err_cnt), .err_flag (err_flag)
`ifdef MCB_RD_ERR_CAPTURE_EN
    , .first_err_addr (first_err_addr), .first_err_beat (first_err_beat),
    .first_err_data (first_err_data), .first_err_exp (first_err_exp)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [AW-1:0] m_addr;
  logic [31:0]   m_pass;
  int            m_err;
  logic          m_flag;
  logic [31:0]   m_lfsr;
  logic [1:0]    m_mode;

  typedef struct {
    logic [1:0]    mode;
    logic [3:0]    corrupt;
    bit            early;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_err;
    logic [31:0]   exp_pass;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    int taps[4] = '{32, 22, 2, 1};
    logic [31:0] mask = 32'h0;
    foreach (taps[i]) mask = mask | (32'h1 << (taps[i] - 1));
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic logic [DW-1:0] model_word(input logic [1:0] md, input logic [AW-1:0] a,
                                               input int b, input logic [31:0] lf);
    logic [31:0] lane;
    lane = 32'(a) + 32'(b);
    if (md == 2'd1) return {4{lane}};
    if (md == 2'd2) return {4{lf}};
    return (b % 2 == 0) ? {16{8'hAA}} : {16{8'h55}};
  endfunction

  task automatic model_start(input logic [1:0] md);
    m_mode = md;
    m_lfsr = 32'hFFFF_FFFF;
  endtask

  task automatic model_mismatch();
    if (m_err < 65535) m_err++;
    m_flag = 1'b1;
  endtask

  task automatic model_burst_end();
    if (m_addr == END_A) begin
      m_addr = '0;
      m_pass = m_pass + 32'd1;
    end else begin
      m_addr = m_addr + INC;
    end
  endtask

  task automatic drive_beat(input int b, input bit bad);
    logic [DW-1:0] w;
    w = model_word(m_mode, m_addr, b, m_lfsr);
    if (bad) w = w ^ (128'h1 << $urandom_range(127, 0));
    rd_valid = 1'b1;
    rd_data  = w;
    m_lfsr   = lfsr_adv(m_lfsr);
    if (bad) model_mismatch();
  endtask

  task automatic wait_cmd(output bit ok);
    int n = 0;
    while (rd_cmd_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (rd_cmd_en === 1'b1);
    if (!ok) check("cmd_timeout", 128'(rd_cmd_en), 128'h1);
  endtask

  // One burst: handshake, BL beats (optionally one early), start drop at beat drop_at
  task automatic do_burst(input logic [3:0] corrupt, input int drop_at, input int lat,
                          input bit early, output logic [AW-1:0] cmd_addr);
    bit ok;
    int b;
    wait_cmd(ok);
    cmd_addr = rd_addr;
    if (!ok) return;
    check("cmd_addr", 128'(rd_addr), 128'(m_addr));
    rd_cmd_done = 1'b1;
    b = 0;
    if (early) begin
      if (drop_at == 0) start = 1'b0;
      drive_beat(0, corrupt[0]);
      b = 1;
    end
    @(negedge clk);
    rd_cmd_done = 1'b0;
    rd_valid    = 1'b0;
    check("cmd_en_drop", 128'(rd_cmd_en), 128'h0);
    if (early) check("err_cnt_beat", 128'(err_cnt), 128'(m_err));
    repeat (lat) @(negedge clk);
    while (b < BL) begin
      if (b == drop_at) start = 1'b0;
      drive_beat(b, corrupt[b]);
      @(negedge clk);
      rd_valid = 1'b0;
      check("err_cnt_beat", 128'(err_cnt), 128'(m_err));
      check("err_flag_beat", 128'(err_flag), 128'(m_flag));
      if (b < BL - 1 && $urandom_range(3, 0) == 0) @(negedge clk);
      b++;
    end
    model_burst_end();
    @(negedge clk);
    check("pass_cnt", 128'(pass_cnt), 128'(m_pass));
    check("next_addr", 128'(rd_addr), 128'(m_addr));
    if (drop_at >= 0) check("busy_after_drop", 128'(busy), 128'h0);
  endtask

  task automatic check_reset_values();
    check("rst_cmd_en", 128'(rd_cmd_en), 128'h0);
    check("rst_addr", 128'(rd_addr), 128'h0);
    check("rst_len", 128'(rd_len), 128'(BL - 1));
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_pass", 128'(pass_cnt), 128'h0);
    check("rst_err_cnt", 128'(err_cnt), 128'h0);
    check("rst_err_flag", 128'(err_flag), 128'h0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err  = 0;
    m_flag = 1'b0;
    check("err_clr_cnt", 128'(err_cnt), 128'h0);
    check("err_clr_flag", 128'(err_flag), 128'h0);
  endtask

  initial begin
    logic [AW-1:0] ca;
    logic [AW-1:0] wrap_seq[4];
    bit ok, seen;
    int nb;

    tbl[0] = '{2'd0, 4'b0000, 1'b0, 30'h000, 16'd0, 32'd0};
    tbl[1] = '{2'd0, 4'b0000, 1'b1, 30'h400, 16'd0, 32'd0};
    tbl[2] = '{2'd1, 4'b0100, 1'b0, 30'h800, 16'd1, 32'd1};
    tbl[3] = '{2'd2, 4'b0000, 1'b1, 30'h000, 16'd1, 32'd1};
    tbl[4] = '{2'd3, 4'b1001, 1'b0, 30'h400, 16'd3, 32'd1};
    tbl[5] = '{2'd2, 4'b0010, 1'b0, 30'h800, 16'd4, 32'd2};
    wrap_seq = '{30'h000, 30'h400, 30'h800, 30'h000};

    rst = 1'b1; start = 1'b0; mode = 2'd0; err_clr = 1'b0;
    rd_cmd_done = 1'b0; rd_valid = 1'b0; rd_data = '0;
    m_addr = '0; m_pass = '0; m_err = 0; m_flag = 1'b0;
    model_start(2'd0);
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single-burst runs, each returning to IDLE
    for (int i = 0; i < 6; i++) begin
      mode  = tbl[i].mode;
      start = 1'b1;
      model_start(tbl[i].mode);
      do_burst(tbl[i].corrupt, BL - 1, 0, tbl[i].early, ca);
      check("tbl_addr", 128'(ca), 128'(tbl[i].exp_addr));
      check("tbl_err", 128'(err_cnt), 128'(tbl[i].exp_err));
      check("tbl_pass", 128'(pass_cnt), 128'(tbl[i].exp_pass));
`ifdef MCB_RD_ERR_CAPTURE_EN
      if (i == 2) begin
        check("first_err_addr", 128'(first_err_addr), 128'h800);
        check("first_err_beat", 128'(first_err_beat), 128'h2);
      end
`endif
      @(negedge clk);
    end

    // Start held across four bursts: wrap after END_ADDR
    pulse_err_clr();
    mode = 2'd1; start = 1'b1;
    model_start(2'd1);
    for (int k = 0; k < 4; k++) begin
      do_burst(4'b0000, (k == 3) ? BL - 1 : -1, 1, 1'b0, ca);
      check("wrap_addr", 128'(ca), 128'(wrap_seq[k]));
    end
    check("wrap_pass", 128'(pass_cnt), 128'h3);

    // start dropped during beat 1; remaining beats still checked
    mode = 2'd0; start = 1'b1;
    model_start(2'd0);
    do_burst(4'b1000, 1, 0, 1'b0, ca);
    check("drop_err", 128'(err_cnt), 128'h1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rd_cmd_en !== 1'b0) seen = 1'b1;
    end
    check("drop_no_cmd", 128'(seen), 128'h0);

    // Spurious beat in IDLE, then clear colliding with a mismatch
    rd_valid = 1'b1; rd_data = {16{8'hAA}};
    model_mismatch();
    @(negedge clk);
    rd_valid = 1'b0;
    check("spurious_err", 128'(err_cnt), 128'(m_err));
    rd_valid = 1'b1;
    pulse_err_clr();
    rd_valid = 1'b0;

    // Randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      mode  = 2'($urandom_range(3, 0));
      start = 1'b1;
      model_start(mode);
      nb = $urandom_range(4, 1);
      for (int k = 0; k < nb; k++) begin
        do_burst(4'($urandom & $urandom), (k == nb - 1) ? $urandom_range(BL - 1, 0) : -1,
                 $urandom_range(3, 0), 1'($urandom_range(1, 0)), ca);
      end
      check("rand_err", 128'(err_cnt), 128'(m_err));
      @(negedge clk);
    end

    // Reset mid-burst, then stale data lands in IDLE
    mode = 2'd0; start = 1'b1;
    model_start(2'd0);
    wait_cmd(ok);
    rd_cmd_done = 1'b1;
    @(negedge clk);
    rd_cmd_done = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(b, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();
    m_addr = '0; m_pass = '0; m_err = 0; m_flag = 1'b0;
    rd_valid = 1'b1;
    repeat (2) begin
      model_mismatch();
      @(negedge clk);
    end
    check("stale_err", 128'(err_cnt), 128'(m_err));

    // Saturation of err_cnt
    while (m_err < 65535) begin
      model_mismatch();
      @(negedge clk);
    end
    check("sat_reach", 128'(err_cnt), 128'hFFFF);
    repeat (3) begin
      model_mismatch();
      @(negedge clk);
    end
    rd_valid = 1'b0;
    check("sat_hold", 128'(err_cnt), 128'(m_err));
    check("sat_flag", 128'(err_flag), 128'h1);
    pulse_err_clr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcb_read_checker.md
# mcb_read_checker

Parametrised DDR3 MCB read-path test engine, successor to the fixed 128-bit AA/55 read checker. It sweeps an address window in fixed bursts through an MCB user read port and compares every returned beat against one of three run-time-selectable patterns. It keeps pass, error and first-error status for the debug/LED layer. It sits between the MCB user read port and the test top, alongside the matching write generator.

## Interface
Parameters:
- DATA_W, 128, user data width; multiple of 32
- ADDR_W, 30, byte address width
- LEN_W, 7, burst-length field width
- BURST_LEN, 64, beats per read command; 1..2^LEN_W
- ADDR_INC, 'h400, byte increment between bursts
- END_ADDR, 'h0FFF_FC00, last burst start address; wraps to 0 after it

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- start  in  1  level; run while high
- mode  in  2  0 = AA/55 alternate, 1 = address-derived, 2 = LFSR, 3 = treated as 0
- err_clr  in  1  one-cycle pulse; clears err_cnt, err_flag, capture
- rd_cmd_en  out  1  read command request
- rd_cmd_done  in  1  command accepted by MCB
- rd_addr  out  ADDR_W  burst start address
- rd_len  out  LEN_W  BURST_LEN-1, MCB encoding
- rd_valid  in  1  rd_data valid this cycle
- rd_data  in  DATA_W  read beat
- busy  out  1  state != IDLE
- pass_cnt  out  32  completed full-window sweeps; wraps at 2^32
- err_cnt  out  16  mismatching beats; saturates at 'hFFFF
- err_flag  out  1  sticky, set by any mismatch

## Operation
- Reset values: rd_cmd_en 0, rd_addr 0, rd_len BURST_LEN-1, busy 0, pass_cnt 0, err_cnt 0, err_flag 0, beat counter 0, LFSR 32'hFFFF_FFFF.
- FSM states: IDLE, ISSUE, WAIT_DATA, NEXT.
  - IDLE: when start = 1, latch mode, go to ISSUE.
  - ISSUE: rd_cmd_en = 1, with rd_addr and rd_len held stable. When rd_cmd_done = 1, drop rd_cmd_en and go to WAIT_DATA.
  - WAIT_DATA: every rd_valid beat is compared and counted. On beat BURST_LEN-1, go to NEXT.
  - NEXT: if rd_addr == END_ADDR, set rd_addr = 0 and increment pass_cnt; otherwise add ADDR_INC. Then go to ISSUE if start = 1, else IDLE.
- Beats with rd_valid in ISSUE are accepted as burst beats (early-data tolerance).
- A beat in IDLE or NEXT is spurious: it counts as a mismatch and is not compared.
- Expected pattern for beat b of a burst at address A:
  - Mode 0: b even gives {DATA_W/8{8'hAA}}; b odd gives {DATA_W/8{8'h55}}.
  - Mode 1: every 32-bit lane = (A[31:0] + b), zero-extended when ADDR_W < 32.
  - Mode 2: a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, replicated across lanes. It is seeded 'hFFFF_FFFF when leaving IDLE and advances once per accepted beat. It is not reseeded per burst.
- start falling mid-burst: the current burst completes, then the FSM goes to IDLE. No outstanding data is abandoned.
- err_clr in the same cycle as a mismatch: the clear wins; that mismatch is lost.
- rst mid-operation: everything returns to reset values immediately. Stale MCB data returned afterwards arrives in IDLE and counts as spurious.

## Timing
- rd_cmd_en asserts in the first cycle of ISSUE. It deasserts the cycle after rd_cmd_done is sampled.
- The compare is registered. err_cnt and err_flag update 1 cycle after the offending beat.
- Burst-to-burst overhead with start held: 2 cycles (NEXT, then ISSUE) plus MCB latency.
- pass_cnt updates on the NEXT cycle of the END_ADDR burst.
- rd_valid may be back-to-back every cycle; no throttling.

## Configuration
- MCB_RD_ERR_CAPTURE_EN defined:
  - Adds outputs first_err_addr (ADDR_W), first_err_beat (LEN_W), first_err_data (DATA_W) and first_err_exp (DATA_W).
  - These are loaded on the first mismatch after reset or err_clr, then held. Reset and clear value is 0.
- Undefined: those ports and registers are absent. All other behaviour is identical.

## Structure
- Package mcb_test_pkg holds:
  - the mode encodings and FSM state enum
  - PAT_AA and PAT_55 byte constants
  - the LFSR seed and tap constant
- Sub-module mcb_pattern_gen, also reused by the write generator:
  - inputs: mode, burst address, beat index, advance, seed
  - output: the expected DATA_W word, combinational from its LFSR register

## Test plan
- Mode 0, BURST_LEN 4, MCB model returns AA, 55, AA, 55 -> err_cnt 0, rd_addr steps 0 -> 'h400.
- Mode 1, data of beat 2 corrupted in the burst at A = 'h800 -> err_cnt 1, err_flag 1 one cycle after the beat. With the macro: first_err_addr 'h800, first_err_beat 2.
- END_ADDR = 2*ADDR_INC, start held for 4 bursts -> address sequence 0, 'h400, 'h800, 0; pass_cnt 1.
- start dropped during beat 1 of 4 -> remaining 3 beats checked, FSM returns to IDLE, no new rd_cmd_en.
- rd_valid in IDLE -> err_cnt +1; err_clr together with a mismatch -> err_cnt 0.
- Mode 2, 10 000 mismatching beats after err_cnt preset near limit -> err_cnt saturates at 'hFFFF; rst mid-burst -> all outputs return to reset values the next cycle.
